// File: rtl/led_shift_ctrl_pkg.sv
// Shared definitions for the LED shift controller: register update modes.
package led_shift_ctrl_pkg;

  // Register behaviour selected by MODE, sampled in the tick cycle only.
  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,  // shift left, key level enters at bit 0
    MODE_SHR  = 2'b01,  // shift right, key level enters at the MSB
    MODE_ROL  = 2'b10,  // rotate left, key ignored
    MODE_HOLD = 2'b11   // no change
  } mode_e;

endpackage

// File: rtl/led_shift_ctrl_key_debounce.sv
// Key conditioning: 2-flop synchroniser, stability debounce and press-edge detect.
//   CLK100MHZ  board clock
//   RESET_N    async active-low reset
//   KEY0       raw button, asynchronous, low = pressed
//   KEY_DB     debounced level, 1 = pressed (registered)
//   rise       one-cycle pulse in the first cycle after KEY_DB goes high
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic RESET_N,
  input  logic KEY0,
  output logic KEY_DB,
  output logic rise
);

  localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             key_db_d;
  logic [DEB_W-1:0] deb_cnt;

  // Synchroniser and stable level idle at 1 (released); KEY_DB is always ~stable.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      deb_cnt  <= '0;
      KEY_DB   <= 1'b0;
      key_db_d <= 1'b0;
    end else begin
      sync1    <= KEY0;
      sync2    <= sync1;
      key_db_d <= KEY_DB;
      if (sync2 != stable) begin
        // Accept the new level once it has differed for DEB_CYCLES consecutive cycles.
        if (deb_cnt == DEB_LAST) begin
          stable  <= sync2;
          KEY_DB  <= ~sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign rise = KEY_DB & ~key_db_d;

endmodule

// File: rtl/led_shift_ctrl.sv
// Tick-driven LED shift register fed by a debounced board key.
//   CLK100MHZ  board clock (single clock domain, tick is a clock enable)
//   RESET_N    async active-low reset
//   KEY0       raw button, low = pressed
//   MODE       00 shift-left-in, 01 shift-right-in, 10 rotate-left, 11 hold
//   LOAD       synchronous parallel load strobe, overrides any shift
//   LOAD_VAL   value captured on LOAD
//   SHIFT_Q    register contents (LEDs)
//   TICK       one-cycle pulse marking each shift cycle
//   KEY_DB     debounced key level, 1 = pressed
module led_shift_ctrl
  import led_shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TICK_DIV   = 33554432,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             CLK100MHZ,
  input  logic             RESET_N,
  input  logic             KEY0,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] SHIFT_Q,
  output logic             TICK,
  output logic             KEY_DB
);

  localparam int unsigned       TICK_W    = $clog2(TICK_DIV) + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic              rise;
  logic              press_latch;
  logic              press_latch_nxt;
  logic              bit_in;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_cnt_nxt;
  logic [WIDTH-1:0]  shift_nxt;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .CLK100MHZ (CLK100MHZ),
    .RESET_N   (RESET_N),
    .KEY0      (KEY0),
    .KEY_DB    (KEY_DB),
    .rise      (rise)
  );

  // Tick phase counter; TICK is registered so it is high exactly while tick_cnt == TICK_LAST.
  always_comb begin
    tick_cnt_nxt = tick_cnt + TICK_W'(1);
    if (tick_cnt == TICK_LAST) begin
      tick_cnt_nxt = '0;
    end
  end

  // Latch remembers a press seen between ticks; consumed (cleared) by every tick.
  always_comb begin
    press_latch_nxt = press_latch;
    if (TICK) begin
      press_latch_nxt = 1'b0;
    end else if (rise) begin
      press_latch_nxt = 1'b1;
    end
  end

  // Register update: LOAD wins over the tick-driven operation.
  always_comb begin
    shift_nxt = SHIFT_Q;
    bit_in    = KEY_DB | press_latch;
    if (LOAD) begin
      shift_nxt = LOAD_VAL;
    end else if (TICK) begin
      case (mode_e'(MODE))
        MODE_SHL: shift_nxt = {SHIFT_Q[WIDTH-2:0], bit_in};
        MODE_SHR: shift_nxt = {bit_in, SHIFT_Q[WIDTH-1:1]};
        MODE_ROL: shift_nxt = {SHIFT_Q[WIDTH-2:0], SHIFT_Q[WIDTH-1]};
        default:  shift_nxt = SHIFT_Q;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt    <= '0;
      TICK        <= 1'b0;
      press_latch <= 1'b0;
      SHIFT_Q     <= '0;
    end else begin
      tick_cnt    <= tick_cnt_nxt;
      TICK        <= (tick_cnt_nxt == TICK_LAST);
      press_latch <= press_latch_nxt;
      SHIFT_Q     <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Self-checking bench for led_shift_ctrl (WIDTH=4, TICK_DIV=4, DEB_CYCLES=3).
module tb_led_shift_ctrl;

  localparam int W    = 4;
  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key0 = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] shift_q;
  logic         tick;
  logic         key_db;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  led_shift_ctrl #(
    .WIDTH      (W),
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB)
  ) dut (
    .CLK100MHZ (clk),
    .RESET_N   (rst_n),
    .KEY0      (key0),
    .MODE      (mode),
    .LOAD      (load),
    .LOAD_VAL  (load_val),
    .SHIFT_Q   (shift_q),
    .TICK      (tick),
    .KEY_DB    (key_db)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: cycle count since reset, raw-key history, press flag.
  int m_q;
  int m_cyc;
  int m_run;
  bit m_kdb;
  bit m_kdb_prev;
  bit m_pending;
  bit m_stable;
  bit m_raw[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 0; m_cyc = 0; m_run = 0;
      m_kdb = 1'b0; m_kdb_prev = 1'b0; m_pending = 1'b0; m_stable = 1'b1;
      m_raw = '{1'b1, 1'b1};
    end else begin
      bit is_tick;
      bit pressed_edge;
      bit b;
      bit synced;
      is_tick      = (m_cyc % TD) == TD - 1;
      pressed_edge = m_kdb && !m_kdb_prev;
      b            = m_kdb || m_pending;
      if (load) begin
        m_q = int'(load_val);
      end else if (is_tick) begin
        case (mode)
          2'd0: m_q = ((m_q * 2) + int'(b)) & MASK;
          2'd1: m_q = (int'(b) * (1 << (W - 1))) + (m_q / 2);
          2'd2: m_q = ((m_q * 2) & MASK) + (m_q / (1 << (W - 1)));
          default: ;
        endcase
      end
      if (is_tick) m_pending = 1'b0;
      else if (pressed_edge) m_pending = 1'b1;
      m_kdb_prev = m_kdb;
      // Key seen by the debouncer is the raw key two edges old.
      synced = m_raw.pop_front();
      m_raw.push_back(key0);
      if (synced != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = synced;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_kdb = !m_stable;
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_shift_q", 32'(shift_q), 32'(m_q));
      check("model_tick", 32'(tick), 32'(((m_cyc % TD) == TD - 1) && rst_n));
      check("model_key_db", 32'(key_db), 32'(m_kdb));
    end
  end

  // Waits for the next TICK and returns SHIFT_Q one cycle after it.
  task automatic next_shift(output logic [W-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no TICK within 20 cycles at %0t", $time);
    end
    @(negedge clk);
    v = shift_q;
  endtask

  task automatic wait_kdb(input logic lvl, output int n);
    n = 0;
    while (key_db !== lvl && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (key_db !== lvl) begin
      tests++;
      fails++;
      $display("FAIL key_db_timeout: level %0b not reached at %0t", lvl, $time);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tick_align_timeout: got %0b expected 1 at %0t", tick, $time);
    end
  endtask

  task automatic load_once(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [W-1:0] v;
  int n;
  logic [W-1:0] exp_rol [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
  logic [W-1:0] exp_shl [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("reset_shift_q", 32'(shift_q), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_key_db", 32'(key_db), 32'h0);
    repeat (2) @(negedge clk);

    // 1: key held low, shift-left-in.
    rst_n = 1'b1;
    key0 = 1'b0;
    mode = 2'b00;
    n = 0;
    while (key_db !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_key_db_latency", 32'(n), 32'd5);
    for (int i = 0; i < 4; i++) begin
      next_shift(v);
      check("t1_shl_fill", 32'(v), 32'(exp_shl[i]));
    end

    // 2: glitch of 2 cycles is rejected.
    key0 = 1'b1;
    wait_kdb(1'b0, n);
    load_once(4'b0000);
    key0 = 1'b0;
    repeat (2) @(negedge clk);
    key0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_shift(v);
      check("t2_glitch_q", 32'(v), 32'h0);
      check("t2_glitch_kdb", 32'(key_db), 32'h0);
    end

    // 3: press just after a tick, counted once at the following ticks.
    wait_tick();
    key0 = 1'b0;
    repeat (5) @(negedge clk);
    key0 = 1'b1;
    next_shift(v);
    check("t3_first", 32'(v), 32'(4'b0001));
    next_shift(v);
    check("t3_second", 32'(v), 32'(4'b0010));

    // 4: rotate, then LOAD coincident with TICK suppresses the rotate.
    mode = 2'b10;
    load_once(4'b1001);
    for (int i = 0; i < 4; i++) begin
      next_shift(v);
      check("t4_rol", 32'(v), 32'(exp_rol[i]));
    end
    wait_tick();
    load_once(4'b1010);
    check("t4_load_on_tick", 32'(shift_q), 32'(4'b1010));
    next_shift(v);
    check("t4_rol_after_load", 32'(v), 32'(4'b0101));

    // 5: shift-right-in with key held, then hold, then mode toggled between ticks.
    mode = 2'b01;
    key0 = 1'b0;
    wait_kdb(1'b1, n);
    load_once(4'b1000);
    next_shift(v);
    check("t5_shr", 32'(v), 32'(4'b1100));
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      next_shift(v);
      check("t5_hold", 32'(v), 32'(4'b1100));
    end
    mode = 2'b00;
    @(negedge clk);
    mode = 2'b11;
    next_shift(v);
    check("t5_toggle_ignored", 32'(v), 32'(4'b1100));

    // 6: async reset mid-debounce and mid-tick-count.
    key0 = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_q", 32'(shift_q), 32'h0);
    check("t6_async_tick", 32'(tick), 32'h0);
    check("t6_async_kdb", 32'(key_db), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_tick_phase", 32'(n), 32'd3);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
